// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Byte-stream bundle between N message sources, the arbiter and one uart_tx.
//   req_data      N*8  byte from source i on bits [8i+7:8i]
//   req_valid     N    source i presents a byte
//   req_last      N    that byte ends the source's packet
//   req_ready     N    byte from source i accepted this cycle
//   tx_data       8    byte toward uart_tx
//   tx_data_valid 1    tx_data is valid
//   tx_data_ready 1    uart_tx accepts tx_data
//   modport slave  : the arbiter's view
//   modport master : the environment's view (sources + uart_tx)
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_data_valid;
  logic           tx_data_ready;

  modport slave (
    input  req_data, req_valid, req_last, tx_data_ready,
    output req_ready, tx_data, tx_data_valid
  );

  modport master (
    output req_data, req_valid, req_last, tx_data_ready,
    input  req_ready, tx_data, tx_data_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin, packet-locked arbiter sharing one uart_tx between N sources.
//   A grant lasts until the source's last byte, MAX_LEN bytes, or TIMEOUT
//   consecutive cycles of the owner starving the UART.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          uart_tx_arbiter_if.slave (source streams and uart_tx side)
//   err_clr      synchronous clear of both sticky error flags
//   grant        one-hot owner of the UART, zero when idle
//   busy         a packet is in progress
//   err_len      sticky: forced release on MAX_LEN
//   err_timeout  sticky: forced release on TIMEOUT
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int MAX_LEN = 80,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_arbiter_if.slave    bus,
  input  logic                err_clr,
  output logic [N-1:0]        grant,
  output logic                busy,
  output logic                err_len,
  output logic                err_timeout
);
  localparam int PW = $clog2(N);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t         state, state_next;
  logic [N-1:0]   grant_next;
  logic [PW-1:0]  ptr, ptr_next;
  logic [LW-1:0]  len, len_next;
  logic [TW-1:0]  tmo, tmo_next;
  logic           set_len, set_tmo;

  logic           sel_found;
  logic [PW-1:0]  sel_idx;
  logic [PW-1:0]  cand;

  logic [7:0]     data_g;
  logic           valid_g;
  logic           last_g;
  logic           xfer;

  // Round-robin search starting just after the last owner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (!sel_found && bus.req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Owner's stream, gated by grant so everything reads zero while idle.
  always_comb begin
    data_g  = '0;
    valid_g = 1'b0;
    last_g  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        data_g  = data_g | bus.req_data[8*i +: 8];
        valid_g = valid_g | bus.req_valid[i];
        last_g  = last_g | bus.req_last[i];
      end
    end
  end

  assign xfer              = valid_g & bus.tx_data_ready;
  assign bus.tx_data       = data_g;
  assign bus.tx_data_valid = valid_g;
  assign bus.req_ready     = grant & {N{bus.tx_data_ready}};
  assign busy              = (state == STREAM);

  always_comb begin
    state_next = state;
    grant_next = grant;
    ptr_next   = ptr;
    len_next   = len;
    tmo_next   = tmo;
    set_len    = 1'b0;
    set_tmo    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_next = STREAM;
          grant_next = {{(N-1){1'b0}}, 1'b1} << sel_idx;
          ptr_next   = sel_idx;
          len_next   = '0;
          tmo_next   = '0;
        end
      end
      STREAM: begin
        if (xfer) begin
          len_next = len + 1'b1;
          tmo_next = '0;
          if (last_g) begin
            state_next = IDLE;
            grant_next = '0;
          end else if (len + 1'b1 == LW'(MAX_LEN)) begin
            state_next = IDLE;
            grant_next = '0;
            set_len    = 1'b1;
          end
        end else if (!valid_g) begin
          // Only starvation by the owner counts; a busy UART holds tmo.
          tmo_next = tmo + 1'b1;
          if (tmo + 1'b1 == TW'(TIMEOUT)) begin
            state_next = IDLE;
            grant_next = '0;
            set_tmo    = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      ptr         <= PW'(N - 1);
      len         <= '0;
      tmo         <= '0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      ptr   <= ptr_next;
      len   <= len_next;
      tmo   <= tmo_next;
      // A set event in the same cycle as err_clr wins.
      if (set_len)      err_len <= 1'b1;
      else if (err_clr) err_len <= 1'b0;
      if (set_tmo)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed stimulus into per-source byte queues; each expected UART byte
//   (source, data) goes into a scoreboard queue, and a monitor pops and
//   compares on every tx handshake.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic       clk;
  logic       rst_n;
  logic       err_clr;
  logic [N-1:0] grant;
  logic       busy;
  logic       err_len;
  logic       err_timeout;

  uart_tx_arbiter_if #(.N(N)) bus ();

  uart_tx_arbiter #(.N(N), .MAX_LEN(80), .TIMEOUT(1024)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .err_clr     (err_clr),
    .grant       (grant),
    .busy        (busy),
    .err_len     (err_len),
    .err_timeout (err_timeout)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_xfer_cyc = 0;
  int ready_mode = 0;
  int rdy_cnt = 0;

  logic [8:0] src_q [N][$];   // {last, data}
  logic [9:0] sb_q [$];       // {src, data}

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_src(input int src, input logic [7:0] data, input logic last);
    src_q[src].push_back({last, data});
  endtask

  task automatic push_exp(input int src, input logic [7:0] data);
    sb_q.push_back({2'(src), data});
  endtask

  task automatic clear_all();
    sb_q.delete();
    for (int i = 0; i < N; i++) src_q[i].delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d bytes outstanding, expected 0", name, sb_q.size());
    end
  endtask

  // Source and uart_tx driver: handshakes sampled at negedge, new values
  // applied just after the posedge.
  initial begin
    logic [N-1:0] fire;
    bus.req_data      = '0;
    bus.req_valid     = '0;
    bus.req_last      = '0;
    bus.tx_data_ready = 1'b1;
    forever begin
      @(negedge clk);
      fire = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire[i] && rst_n && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          bus.req_valid[i]      = 1'b1;
          bus.req_data[8*i +: 8] = src_q[i][0][7:0];
          bus.req_last[i]       = src_q[i][0][8];
        end else begin
          bus.req_valid[i]      = 1'b0;
          bus.req_data[8*i +: 8] = 8'h00;
          bus.req_last[i]       = 1'b0;
        end
      end
      bus.tx_data_ready = (ready_mode == 0) || (rdy_cnt == 0);
      rdy_cnt = (rdy_cnt + 1) % 10;
    end
  end

  // Monitor: one line per transferred byte.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.tx_data_valid && bus.tx_data_ready) begin
        last_xfer_cyc = cyc;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected byte: got %02h grant %b, expected none", bus.tx_data, grant);
        end else begin
          e = sb_q.pop_front();
          $display("byte cyc=%0d grant=%b data=%02h exp_src=%0d exp_data=%02h", cyc, grant, bus.tx_data, e[9:8], e[7:0]);
          check("tx_data", 32'(bus.tx_data), 32'(e[7:0]));
          check("tx_grant", 32'(grant), 32'(4'b0001 << e[9:8]));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    err_clr = 1'b0;
    do_reset();

    // Reset state
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_tx_valid", 32'(bus.tx_data_valid), 32'h0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_errs", 32'({err_len, err_timeout}), 32'h0);

    // Single requester "HI\n"
    push_src(0, 8'h48, 1'b0); push_exp(0, 8'h48);
    push_src(0, 8'h49, 1'b0); push_exp(0, 8'h49);
    push_src(0, 8'h0A, 1'b1); push_exp(0, 8'h0A);
    @(negedge clk);
    check("single_req_seen", 32'(bus.req_valid[0]), 32'h1);
    check("single_grant_t", 32'(grant), 32'h0);
    @(negedge clk);
    check("single_grant_t1", 32'(grant), 32'h1);
    check("single_busy_t1", 32'(busy), 32'h1);
    check("single_valid_t1", 32'(bus.tx_data_valid), 32'h1);
    repeat (3) @(negedge clk);
    check("single_release", 32'(grant), 32'h0);
    check("single_sb_empty", 32'(sb_q.size()), 32'h0);
    check("single_errs", 32'({err_len, err_timeout}), 32'h0);

    // Contention: 0, 1, 3 with UART ready every 10 cycles
    do_reset();
    ready_mode = 1;
    for (int b = 0; b < 3; b++) push_src(0, 8'h10 + 8'(b), b == 2);
    for (int b = 0; b < 3; b++) push_src(1, 8'h20 + 8'(b), b == 2);
    for (int b = 0; b < 3; b++) push_src(3, 8'h30 + 8'(b), b == 2);
    for (int b = 0; b < 3; b++) push_exp(0, 8'h10 + 8'(b));
    for (int b = 0; b < 3; b++) push_exp(1, 8'h20 + 8'(b));
    for (int b = 0; b < 3; b++) push_exp(3, 8'h30 + 8'(b));
    wait_drain("contention", 500);

    // Wrap-around: ptr is now 3, sources 0 and 2 request
    push_src(2, 8'h52, 1'b1);
    push_src(0, 8'h50, 1'b1);
    push_exp(0, 8'h50);
    push_exp(2, 8'h52);
    @(negedge clk);
    @(negedge clk);
    check("wrap_grant", 32'(grant), 32'h1);
    wait_drain("wrap", 200);
    ready_mode = 0;

    // Length guard: source 2 streams 100 bytes, source 3 waits
    do_reset();
    for (int b = 0; b < 100; b++) push_src(2, 8'(b), 1'b0);
    push_src(3, 8'hA0, 1'b0);
    push_src(3, 8'hA1, 1'b1);
    for (int b = 0; b < 80; b++) push_exp(2, 8'(b));
    push_exp(3, 8'hA0);
    push_exp(3, 8'hA1);
    for (int b = 80; b < 100; b++) push_exp(2, 8'(b));
    wait_drain("len", 400);
    check("len_err_len", 32'(err_len), 32'h1);
    check("len_err_timeout", 32'(err_timeout), 32'h0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("len_err_clr", 32'(err_len), 32'h0);

    // Stall timeout: 2 bytes then 1024 starved cycles
    do_reset();
    push_src(1, 8'h61, 1'b0); push_exp(1, 8'h61);
    push_src(1, 8'h62, 1'b0); push_exp(1, 8'h62);
    wait_drain("tmo1024", 50);
    n = 0;
    while (grant != 0 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check("tmo_release_cycles", 32'(cyc - last_xfer_cyc), 32'd1025);
    check("tmo_err_timeout", 32'(err_timeout), 32'h1);
    check("tmo_err_len", 32'(err_len), 32'h0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("tmo_err_clr", 32'(err_timeout), 32'h0);

    // 1023-cycle gap: no release, packet completes
    push_src(1, 8'h71, 1'b0); push_exp(1, 8'h71);
    push_src(1, 8'h72, 1'b0); push_exp(1, 8'h72);
    wait_drain("tmo1023a", 50);
    while (cyc < last_xfer_cyc + 1023) @(negedge clk);
    check("tmo1023_still_granted", 32'(grant), 32'h2);
    push_src(1, 8'h73, 1'b1); push_exp(1, 8'h73);
    wait_drain("tmo1023b", 50);
    @(negedge clk);
    check("tmo1023_err_timeout", 32'(err_timeout), 32'h0);
    check("tmo1023_idle", 32'(grant), 32'h0);

    // Async reset during byte 5
    do_reset();
    for (int b = 1; b <= 8; b++) begin
      push_src(1, 8'h80 + 8'(b), b == 8);
      push_exp(1, 8'h80 + 8'(b));
    end
    n = 0;
    while (sb_q.size() > 4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 32'h0);
    check("arst_tx_valid", 32'(bus.tx_data_valid), 32'h0);
    check("arst_req_ready", 32'(bus.req_ready), 32'h0);
    clear_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_src(1, 8'h91, 1'b1);
    push_src(0, 8'h90, 1'b1);
    push_exp(0, 8'h90);
    push_exp(1, 8'h91);
    @(negedge clk);
    @(negedge clk);
    check("arst_first_prio", 32'(grant), 32'h1);
    wait_drain("arst", 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-locked arbiter that shares one `uart_tx` byte transmitter between N message sources, e.g. string writers, status reporters and debug dumpers. Each source streams bytes with a valid/ready handshake and marks its final byte with `last`. Packets are never interleaved on the serial line. The block sits between the sources and the `uart_tx` instance. It adds a length guard and a stall timeout so that a faulty source cannot hold the UART indefinitely.

## Interface
- `N`, default 4: number of requesters (2..8).
- `MAX_LEN`, default 80: maximum number of bytes per grant before forced release.
- `TIMEOUT`, default 1024: cycles a granted requester may hold `req_valid` low mid-packet before forced release.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `req_data`, input, N*8: byte from requester i on bits [8i+7:8i].
- `req_valid`, input, N: requester i has a byte.
- `req_last`, input, N: the byte from requester i is the last of its packet. Only meaningful with `req_valid[i]`.
- `req_ready`, output, N: the byte from requester i is accepted this cycle.
- `tx_data`, output, 8: byte to `uart_tx`.
- `tx_data_valid`, output, 1: byte to `uart_tx` is valid.
- `tx_data_ready`, input, 1: `uart_tx` accepts the byte.
- `grant`, output, N: one-hot owner of the UART. Zero when idle.
- `busy`, output, 1: a packet is in progress (state STREAM).
- `err_len`, output, 1: sticky. Set on a forced release caused by `MAX_LEN`.
- `err_timeout`, output, 1: sticky. Set on a forced release caused by `TIMEOUT`.
- `err_clr`, input, 1: synchronous clear of both sticky error flags.

## Operation
- States: IDLE and STREAM.
- Internal registers:
  - `ptr`: index of the last granted requester. Reset value N-1, so requester 0 wins first.
  - `len`: $clog2(MAX_LEN+1) bits.
  - `tmo`: $clog2(TIMEOUT+1) bits.
- IDLE behaviour:
  - If `req_valid` is nonzero, select the first i with `req_valid[i]` set, searching (ptr+1) mod N, (ptr+2) mod N, and so on, wrapping around.
  - Register `grant` to one-hot i, set `ptr` to i, clear `len` and `tmo`, and go to STREAM.
  - If `req_valid` is zero, stay in IDLE.
- STREAM outputs, with g the granted index:
  - `tx_data` = `req_data[g]`.
  - `tx_data_valid` = `req_valid[g]`.
  - `req_ready[g]` = `tx_data_ready`.
  - All other `req_ready` bits are 0.
  - These are combinational pass-throughs of registered `grant`.
- Transfer: a transfer occurs when `tx_data_valid` and `tx_data_ready` are both high. Each transfer increments `len` and clears `tmo`.
- STREAM exits. Each exit goes to IDLE and clears `grant`.
  - A transfer with `req_last[g]` high: normal end of packet.
  - A transfer that makes `len` equal `MAX_LEN` without `last`: set `err_len`.
  - `req_valid[g]` low for TIMEOUT consecutive cycles, so that `tmo` reaches TIMEOUT: set `err_timeout`.
- While `req_valid[g]` is high and no transfer occurs (UART busy), `tmo` holds. Only source starvation counts toward the timeout.
- Non-granted requesters never see `req_ready` high. They must hold `req_valid`, `req_data` and `req_last` stable until accepted.
- `err_clr` and a set event in the same cycle: the set wins.
- Reset mid-packet: all state returns to reset values immediately. The UART may be left mid-byte, which is the responsibility of `uart_tx`.

## Timing
- Reset values:
  - Outputs: `grant`=0, `busy`=0, `tx_data_valid`=0, `req_ready`=0, `tx_data`=0 (data mux gated to 0 when idle), `err_len`=0, `err_timeout`=0.
  - Internal: `ptr`=N-1.
- Arbitration latency: `req_valid` rises in IDLE at cycle t. `grant` and `busy` are high at t+1, and `tx_data_valid` can be high at t+1.
- Packet turnaround: the last transfer occurs at cycle t. IDLE at t+1, next `grant` at t+2. There is exactly one dead cycle between packets.
- Throughput: one byte per `tx_data_ready` pulse. The block adds no stall inside a packet.
- `req_valid[i]` rising in the same cycle as the selection is included in that cycle's selection.
- `MAX_LEN`=1 degenerates to byte-level round robin, with `err_len` set on every byte that is not a `last` byte.

## Test plan
- **Single requester packet.** After reset, requester 0 sends "HI\n", with `last` on 0x0A, and `tx_data_ready` is always high.
  - `grant`=0001 one cycle after `req_valid`.
  - `tx_data` sequence is 0x48, 0x49, 0x0A on consecutive cycles.
  - `grant`=0 the cycle after 0x0A.
  - No error flags are set.
- **Contention and fairness.** Requesters 0, 1 and 3 each hold a 3-byte packet, with `uart_tx` ready once every 10 cycles.
  - Grant order is 0, 1, 3, then 0 again if 0 re-requests.
  - The bytes of each packet are contiguous on `tx_data` and never interleaved.
- **Wrap-around.** With `ptr`=3, requesters 0 and 2 request.
  - Requester 0 is granted.
- **Length guard.** With `MAX_LEN`=80, requester 2 streams 100 bytes with no `last`.
  - Release occurs after the 80th transfer and `err_len`=1.
  - The next grant goes to the next requester in round-robin order.
  - `err_clr` returns `err_len` to 0.
- **Stall timeout.** Requester 1 sends 2 bytes, then holds `req_valid` low for 1024 cycles.
  - Release occurs and `err_timeout`=1.
  - Repeat with a 1023-cycle gap: no release, and the packet completes normally.
- **Async reset mid-packet.** `rst_n` is asserted during byte 5 of a packet.
  - `grant`, `tx_data_valid` and `req_ready` go to 0 without waiting for a clock edge.
  - After release of `rst_n`, requester 0 has first priority.
